// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address field widths, load/store function codes and FSM encoding.
package dcache_pkg;

  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = 128;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_sz_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_BACK = 2'd1,
    ST_MEM_READ   = 2'd2,
    ST_UPDATE     = 2'd3
  } state_e;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side request/response and 128-bit block memory port of the data cache.
interface data_cache_if;
  import dcache_pkg::*;

  logic [3:0]                 READ;
  logic [2:0]                 WRITE;
  logic [31:0]                ADDRESS;
  logic [31:0]                WRITEDATA;
  logic [31:0]                READDATA;
  logic                       BUSYWAIT;
  logic                       MEM_READ;
  logic                       MEM_WRITE;
  logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS;
  logic [BLOCK_W-1:0]         MEM_WRITEDATA;
  logic [BLOCK_W-1:0]         MEM_READDATA;
  logic                       MEM_BUSYWAIT;

  // Cache view: serves the CPU, drives the memory request.
  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  // Environment view: CPU requester plus backing memory.
  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_lane_align.sv
// Combinational byte-lane logic: load extract with sign/zero extension and
// store merge of a byte/half/word into a 128-bit cache line.
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [BLOCK_W-1:0]  line,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [2:0]          load_f3,
  input  logic [1:0]          store_sz,
  input  logic [31:0]         store_data,
  output logic [31:0]         load_data,
  output logic [BLOCK_W-1:0]  merged_line
);

  logic [31:0] word;
  logic [31:0] new_word;
  logic [31:0] store_rep;
  logic [3:0]  byte_en;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    word   = line[{offset[3:2], 5'd0} +: 32];
    lane_b = word[{offset[1:0], 3'd0} +: 8];
    lane_h = word[{offset[1], 4'd0} +: 16];

    case (load_f3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LW:   load_data = word;
      F3_LBU:  load_data = {24'd0, lane_b};
      F3_LHU:  load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase

    // Replicating the store data lets every lane take its own slice.
    case (store_sz)
      ST_SB: begin
        byte_en   = 4'b0001 << offset[1:0];
        store_rep = {4{store_data[7:0]}};
      end
      ST_SH: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data[15:0]}};
      end
      ST_SW: begin
        byte_en   = 4'b1111;
        store_rep = store_data;
      end
      default: begin
        byte_en   = '0;
        store_rep = '0;
      end
    endcase

    new_word = word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) new_word[b*8 +: 8] = store_rep[b*8 +: 8];
    end

    merged_line = line;
    merged_line[{offset[3:2], 5'd0} +: 32] = new_word;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a
// write-back / block-refill FSM towards a 128-bit main memory port.
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  data_cache_if.slave  bus
);

  localparam int IDX_W    = $clog2(LINES);
  localparam int TAG_BITS = 32 - IDX_W - OFFSET_W;
  localparam int LINE_W   = BLOCK_WORDS * 32;

  state_e state, state_nxt;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [LINE_W-1:0]   data_arr [LINES];
  logic [LINE_W-1:0]   refill_buf;

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   merged_line;
  logic [31:0]         load_data;
  logic                access, is_load, hit, store_hit;
  logic                refill_en, update_en;

  assign req_tag   = bus.ADDRESS[31 -: TAG_BITS];
  assign req_idx   = bus.ADDRESS[OFFSET_W +: IDX_W];
  assign line_q    = data_arr[req_idx];
  assign access    = bus.READ[3] | bus.WRITE[2];
  // A simultaneous load and store is executed as the store alone.
  assign is_load   = bus.READ[3] & ~bus.WRITE[2];
  assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign store_hit = (state == ST_IDLE) && bus.WRITE[2] && hit;

  dcache_lane_align u_align (
    .line        (line_q),
    .offset      (bus.ADDRESS[OFFSET_W-1:0]),
    .load_f3     (bus.READ[2:0]),
    .store_sz    (bus.WRITE[1:0]),
    .store_data  (bus.WRITEDATA),
    .load_data   (load_data),
    .merged_line (merged_line)
  );

  assign bus.BUSYWAIT = access && (!hit || state != ST_IDLE);
  assign bus.READDATA = (!RESET && state == ST_IDLE && is_load && hit) ? load_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt         = state;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = '0;
    bus.MEM_WRITEDATA = '0;
    refill_en         = 1'b0;
    update_en         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && !hit)
          state_nxt = (valid[req_idx] && dirty[req_idx]) ? ST_WRITE_BACK : ST_MEM_READ;
      end
      ST_WRITE_BACK: begin
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDRESS   = {tag_arr[req_idx], req_idx};
        bus.MEM_WRITEDATA = line_q;
        if (!bus.MEM_BUSYWAIT) state_nxt = ST_MEM_READ;
      end
      ST_MEM_READ: begin
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = {req_tag, req_idx};
        if (!bus.MEM_BUSYWAIT) begin
          refill_en = 1'b1;
          state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        update_en = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (update_en) begin
      valid[req_idx] <= 1'b1;
      dirty[req_idx] <= 1'b0;
    end else if (store_hit) begin
      dirty[req_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data storage and the refill buffer are not reset; the
  // cleared valid bits make their contents irrelevant until refilled.
  always_ff @(posedge CLK) begin
    if (refill_en) refill_buf <= bus.MEM_READDATA;
    if (update_en) begin
      data_arr[req_idx] <= refill_buf;
      tag_arr[req_idx]  <= req_tag;
    end else if (store_hit) begin
      data_arr[req_idx] <= merged_line;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random
// traffic compared against a behavioural cache and memory model.
module tb_data_cache;
  import dcache_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  data_cache_if bus ();

  data_cache #(.LINES(8), .BLOCK_WORDS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- backing memory (driven by the cache) ----------------
  logic [127:0] mem     [logic [27:0]];
  logic [127:0] ref_mem [logic [27:0]];
  int mem_lat = 3;
  int mem_cnt = 0;

  function automatic logic [127:0] init_block(logic [27:0] a);
    logic [127:0] blk;
    logic [1:0]   wv;
    for (int w = 0; w < 4; w++) begin
      wv = 2'(w);
      blk[w*32 +: 32] = {a, wv, 2'b01};
    end
    return blk;
  endfunction

  function automatic logic [127:0] mem_get(logic [27:0] a);
    return mem.exists(a) ? mem[a] : init_block(a);
  endfunction

  function automatic logic [127:0] ref_get(logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_block(a);
  endfunction

  // Memory answers on the mem_lat-th cycle of a request.
  always @(negedge CLK) begin
    bus.MEM_BUSYWAIT = !((bus.MEM_READ || bus.MEM_WRITE) && mem_cnt >= mem_lat - 1);
    bus.MEM_READDATA = bus.MEM_READ ? mem_get(bus.MEM_ADDRESS) : '0;
  end

  always @(posedge CLK) begin
    if (RESET || !(bus.MEM_READ || bus.MEM_WRITE)) begin
      mem_cnt = 0;
    end else if (!bus.MEM_BUSYWAIT) begin
      if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
      mem_cnt = 0;
    end else begin
      mem_cnt++;
    end
  end

  // ---------------- reference cache model ----------------
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_line  [8];

  function automatic logic [31:0] model_load(logic [127:0] line, logic [31:0] addr, logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = 32'(line >> (32 * addr[3:2]));
    b = 8'(w >> (8 * addr[1:0]));
    h = 16'(w >> (16 * addr[1]));
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [127:0] model_store(logic [127:0] line, logic [31:0] addr,
                                               logic [1:0] sz, logic [31:0] data);
    logic [31:0]  w, mask;
    logic [127:0] mask128;
    int sh;
    case (sz)
      2'b00:   sh = 8 * addr[1:0];
      2'b01:   sh = 16 * addr[1];
      default: sh = 0;
    endcase
    case (sz)
      2'b00:   mask = 32'h0000_00FF << sh;
      2'b01:   mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    w = 32'(line >> (32 * addr[3:2]));
    w = (w & ~mask) | ((data << sh) & mask);
    mask128 = 128'hFFFF_FFFF << (32 * addr[3:2]);
    return (line & ~mask128) | ({96'd0, w} << (32 * addr[3:2]));
  endfunction

  // ---------------- CPU request driver ----------------
  logic [31:0]  last_rdata;
  int           last_stall;
  logic [27:0]  seen_wr_addr, seen_rd_addr;
  logic [127:0] seen_wr_data;
  int           n_wr, n_rd;

  // Starts and ends on a negedge; compares the whole transaction to the model.
  task automatic cpu_op(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [2:0]   idx      = addr[6:4];
    logic [24:0]  tg       = addr[31:7];
    logic [27:0]  blk      = addr[31:4];
    bit           is_acc   = rd[3] | wr[2];
    bit           is_ld    = rd[3] & ~wr[2];
    bit           m_hit    = m_valid[idx] && (m_tag[idx] == tg);
    bit           wb       = is_acc && !m_hit && m_valid[idx] && m_dirty[idx];
    logic [127:0] victim   = m_line[idx];
    logic [27:0]  vic_addr = {m_tag[idx], idx};
    int           exp_stall;
    logic [31:0]  exp_rdata;

    exp_stall = (!is_acc || m_hit) ? 0 : (wb ? 2 + 2 * mem_lat : 2 + mem_lat);

    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = addr;
    bus.WRITEDATA = wdata;
    last_stall    = 0;
    n_wr          = 0;
    n_rd          = 0;
    seen_wr_addr  = '0;
    seen_wr_data  = '0;
    seen_rd_addr  = '0;
    #1;
    while (bus.BUSYWAIT && last_stall < 100) begin
      if (bus.MEM_WRITE) begin
        if (n_wr == 0) begin
          seen_wr_addr = bus.MEM_ADDRESS;
          seen_wr_data = bus.MEM_WRITEDATA;
        end
        n_wr++;
      end
      if (bus.MEM_READ) begin
        if (n_rd == 0) seen_rd_addr = bus.MEM_ADDRESS;
        n_rd++;
      end
      last_stall++;
      @(negedge CLK);
      #1;
    end
    last_rdata = bus.READDATA;

    if (is_acc && !m_hit) begin
      if (wb) ref_mem[vic_addr] = victim;
      m_line[idx]  = ref_get(blk);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rdata = is_ld ? model_load(m_line[idx], addr, rd[2:0]) : 32'd0;

    check({tag, "_stall"}, 128'(last_stall), 128'(exp_stall));
    check({tag, "_rdata"}, 128'(last_rdata), 128'(exp_rdata));
    check({tag, "_nwr"}, 128'(n_wr), 128'(wb ? mem_lat : 0));
    check({tag, "_nrd"}, 128'(n_rd), 128'((is_acc && !m_hit) ? mem_lat : 0));
    if (is_acc && !m_hit) check({tag, "_rdaddr"}, 128'(seen_rd_addr), 128'(blk));
    if (wb) begin
      check({tag, "_wbaddr"}, 128'(seen_wr_addr), 128'(vic_addr));
      check({tag, "_wbdata"}, seen_wr_data, victim);
    end

    if (wr[2]) begin
      m_line[idx]  = model_store(m_line[idx], addr, wr[1:0], wdata);
      m_dirty[idx] = 1'b1;
    end

    @(posedge CLK);
    @(negedge CLK);
    bus.READ  = 4'd0;
    bus.WRITE = 3'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [2:0] load_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    logic [127:0] blk4;
    int           waited;
    int           r;
    logic [31:0]  a;

    bus.READ          = 4'd0;
    bus.WRITE         = 3'd0;
    bus.ADDRESS       = 32'd0;
    bus.WRITEDATA     = 32'd0;
    bus.MEM_BUSYWAIT  = 1'b1;
    bus.MEM_READDATA  = '0;
    RESET             = 1'b1;

    // Reset: every output is zero in the cycle after RESET is sampled.
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_readdata", 128'(bus.READDATA), 128'd0);
    check("rst_busywait", 128'(bus.BUSYWAIT), 128'd0);
    check("rst_mem_read", 128'(bus.MEM_READ), 128'd0);
    check("rst_mem_write", 128'(bus.MEM_WRITE), 128'd0);
    check("rst_mem_addr", 128'(bus.MEM_ADDRESS), 128'd0);
    check("rst_mem_wdata", bus.MEM_WRITEDATA, 128'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Cold load from block 4, memory answers on the third request cycle.
    blk4 = init_block(28'h4);
    blk4[31:0] = 32'hDEAD_BEEF;
    mem[28'h4]     = blk4;
    ref_mem[28'h4] = blk4;
    mem_lat = 3;
    cpu_op("lw_cold", 4'b1010, 3'b000, 32'h0000_0040, 32'd0);
    check("cold_stall5", 128'(last_stall), 128'd5);
    check("cold_rd_addr", 128'(seen_rd_addr), 128'h4);
    check("cold_data", 128'(last_rdata), 128'hDEAD_BEEF);
    cpu_op("lw_again", 4'b1010, 3'b000, 32'h0000_0040, 32'd0);
    check("again_nomem", 128'(n_rd), 128'd0);

    // Sub-word loads on the hit line.
    cpu_op("lb_43", 4'b1000, 3'b000, 32'h0000_0043, 32'd0);
    check("lb_43_val", 128'(last_rdata), 128'hFFFF_FFDE);
    cpu_op("lbu_43", 4'b1100, 3'b000, 32'h0000_0043, 32'd0);
    check("lbu_43_val", 128'(last_rdata), 128'h0000_00DE);
    cpu_op("lh_42", 4'b1001, 3'b000, 32'h0000_0042, 32'd0);
    check("lh_42_val", 128'(last_rdata), 128'hFFFF_DEAD);
    cpu_op("lhu_40", 4'b1101, 3'b000, 32'h0000_0040, 32'd0);
    check("lhu_40_val", 128'(last_rdata), 128'h0000_BEEF);

    // Store byte on hit, then read the merged word back.
    cpu_op("sb_41", 4'b0000, 3'b100, 32'h0000_0041, 32'h0000_0055);
    check("sb_41_nostall", 128'(last_stall), 128'd0);
    cpu_op("lw_merged", 4'b1010, 3'b000, 32'h0000_0040, 32'd0);
    check("lw_merged_val", 128'(last_rdata), 128'hDEAD_55EF);

    // Conflicting tag on the dirty line forces a write-back first.
    cpu_op("lw_conflict", 4'b1010, 3'b000, 32'h0000_00C0, 32'd0);
    check("wb_addr4", 128'(seen_wr_addr), 128'h4);
    check("wb_word0", 128'(seen_wr_data[31:0]), 128'hDEAD_55EF);
    check("refill_addrC", 128'(seen_rd_addr), 128'hC);

    // Reset in the middle of a refill aborts it.
    mem_lat = 4;
    bus.READ    = 4'b1010;
    bus.WRITE   = 3'b000;
    bus.ADDRESS = 32'h0000_0140;
    waited = 0;
    #1;
    while (!bus.MEM_READ && waited < 10) begin
      waited++;
      @(negedge CLK);
      #1;
    end
    check("abort_in_read", 128'(bus.MEM_READ), 128'd1);
    RESET     = 1'b1;
    bus.READ  = 4'd0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("abort_mem_read", 128'(bus.MEM_READ), 128'd0);
    check("abort_mem_addr", 128'(bus.MEM_ADDRESS), 128'd0);
    check("abort_busywait", 128'(bus.BUSYWAIT), 128'd0);
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    @(negedge CLK);
    cpu_op("lw_post_reset", 4'b1010, 3'b000, 32'h0000_0040, 32'd0);
    check("post_reset_miss", 128'(last_stall), 128'd6);

    // Load and store together: executed as SW, no load data.
    cpu_op("rw_both", 4'b1010, 3'b110, 32'h0000_0044, 32'h1234_5678);
    check("rw_both_rdata0", 128'(last_rdata), 128'd0);
    cpu_op("rw_readback", 4'b1010, 3'b000, 32'h0000_0044, 32'd0);
    check("rw_readback_val", 128'(last_rdata), 128'h1234_5678);

    // Random traffic over a few tags so hits, conflicts and write-backs mix.
    for (int n = 0; n < 300; n++) begin
      mem_lat = $urandom_range(1, 4);
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      r = $urandom_range(0, 9);
      if (r == 0)
        cpu_op("rnd_idle", 4'b0000, 3'b000, a, $urandom);
      else if (r <= 5)
        cpu_op("rnd_load", {1'b1, load_codes[$urandom_range(0, 4)]}, 3'b000, a, $urandom);
      else if (r <= 8)
        cpu_op("rnd_store", 4'b0000, {1'b1, 2'($urandom_range(0, 2))}, a, $urandom);
      else
        cpu_op("rnd_both", 4'b1010, {1'b1, 2'($urandom_range(0, 2))}, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and main data memory.
- Consumes the CPU data-memory request (read/write control, address, write data) and returns load data (sign/zero-extended) plus BUSYWAIT.
- On a miss it runs a block refill, preceded by a write-back if the victim line is dirty, over a 128-bit block interface to main memory.

Parameters:
- LINES, 8, number of cache lines; power of two; index width = log2(LINES).
- BLOCK_WORDS, 4, 32-bit words per line; fixed at 4 (128-bit memory port).

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- READ  in  4  bit3 = load enable; [2:0] = funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- WRITE  in  3  bit2 = store enable; [1:0]: 00 SB, 01 SH, 10 SW.
- ADDRESS  in  32  byte address.
- WRITEDATA  in  32  store data, right-aligned.
- READDATA  out  32  extended load data.
- BUSYWAIT  out  1  CPU stall request.
- MEM_READ  out  1  block read request.
- MEM_WRITE  out  1  block write request.
- MEM_ADDRESS  out  28  block address (byte address >> 4).
- MEM_WRITEDATA  out  128  victim block, word0 in [31:0].
- MEM_READDATA  in  128  refill block, word0 in [31:0].
- MEM_BUSYWAIT  in  1  memory not yet done; the request is complete in the cycle it is low while MEM_READ or MEM_WRITE is high.

Behaviour:
- Address split (LINES=8): tag = ADDRESS[31:7] (25 bits), index = [6:4], word = [3:2], byte = [1:0].
- Per-line state: valid, dirty, tag, 128-bit data.
- Access: access = READ[3] | WRITE[2].
- Hit: hit = valid[index] && tag match.
- BUSYWAIT is combinational: 1 when access && (!hit || state != IDLE), else 0.
- Load hit: zero-stall. READDATA is combinational in the same cycle.
  - LW: whole word; ADDRESS[1:0] ignored.
  - LH/LHU: half selected by ADDRESS[1], sign/zero-extended.
  - LB/LBU: byte selected by ADDRESS[1:0], sign/zero-extended.
- READDATA is 0 when no load is active, and 0 on reset.
- Store hit: at the posedge in IDLE, merge bytes into the line and set dirty.
  - SW: full word; ADDRESS[1:0] ignored.
  - SH: half selected by ADDRESS[1].
  - SB: byte selected by ADDRESS[1:0].
- Simultaneous READ[3] and WRITE[2]: treated as a store; READDATA = 0.
- FSM states: IDLE, WRITE_BACK, MEM_READ, UPDATE.
  - IDLE: on access && !hit, go to WRITE_BACK if valid && dirty, else to MEM_READ. Otherwise stay.
  - WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={old tag, index}, MEM_WRITEDATA=line data. When MEM_BUSYWAIT=0, go to MEM_READ.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS={req tag, index}. When MEM_BUSYWAIT=0, capture MEM_READDATA into a refill buffer and go to UPDATE.
  - UPDATE: at the posedge, write the buffer into the line; set valid=1, dirty=0, tag=req tag. Go to IDLE.
  - Back in IDLE the request now hits: load data appears, or the store merges and sets dirty. BUSYWAIT drops in that cycle.
- Outputs by state: MEM_READ and MEM_WRITE are 0 outside their states. MEM_ADDRESS and MEM_WRITEDATA are 0 in IDLE and UPDATE.
- Miss stall:
  - Clean: 1 (IDLE) + N_read (MEM_READ cycles) + 1 (UPDATE) cycles of BUSYWAIT.
  - Dirty: additionally + N_write (WRITE_BACK cycles).
- Request fields ADDRESS/WRITEDATA/READ/WRITE are required to stay stable while BUSYWAIT=1; the cache does not latch them.
- Reset: all valid and dirty bits cleared, state=IDLE. Every output is 0 in the cycle after RESET is sampled, except READDATA and BUSYWAIT, which follow their combinational rules.
- Reset mid-refill or mid-write-back aborts the transfer; the memory request drops the following cycle. Data arrays are not cleared.
- Wrap-around: a store to the last byte of a line touches only that line; no cross-line accesses exist.

Decomposition:
- Shared package dcache_pkg:
  - funct3 load/store codes.
  - FSM state encoding (2-bit).
  - TAG_W, INDEX_W, OFFSET_W constants.
- Sub-module dcache_lane_align (combinational): load byte/half extract with sign/zero extension, and store byte-lane merge into a 128-bit line.
- The top holds the arrays, FSM, refill buffer and port muxing.

Test Plan:
- Cold LW 0x0000_0040, memory returns block word0=0xDEADBEEF after 3 MEM_BUSYWAIT cycles -> MEM_READ=1 with MEM_ADDRESS=0x0000004; BUSYWAIT for exactly 5 cycles; READDATA=0xDEADBEEF; repeat LW -> BUSYWAIT=0, no MEM_READ.
- After the above: LB 0x43 -> 0xFFFFFFDE; LBU 0x43 -> 0x000000DE; LH 0x42 -> 0xFFFFDEAD; LHU 0x40 -> 0x0000BEEF; all zero-stall.
- SB 0x41 data 0x55 on hit -> zero-stall; then LW 0x40 -> 0xDEAD55EF; line dirty.
- LW 0x0000_00C0 (same index 4, different tag) while dirty -> WRITE_BACK first: MEM_WRITE=1, MEM_ADDRESS=0x0000004, MEM_WRITEDATA[31:0]=0xDEAD55EF; then MEM_READ with MEM_ADDRESS=0x000000C.
- RESET asserted during MEM_READ -> MEM_READ=0 next cycle; state IDLE; a subsequent LW 0x40 misses (valid cleared).
- READ=4'b1010 and WRITE=3'b110 together on hit -> treated as SW; READDATA=0; word updated.
